// File: rtl/int_ctrl_pkg.sv
// int_ctrl shared constants: register offsets, GIE bit, FSM states.
// Imported by the interrupt controller top.
package int_ctrl_pkg;

  localparam logic [31:0] MASK_OFF   = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;
  localparam int          SEL_BIT    = 2;
  localparam int          GIE_BIT    = 0;

  typedef enum logic [1:0] {
    S_IC_IDLE = 2'b00,
    S_IC_REQ  = 2'b01,
    S_IC_SVC  = 2'b10
  } ic_state_e;

endpackage

// File: rtl/int_pending.sv
// Edge detect on irq lines into sticky pending bits.
// A new edge in the same cycle as a W1C clear keeps the bit set.
module int_pending #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] clr,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr) | (irq & ~irq_q);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: MASK/STATUS window, request FSM and
// int/int_ack handshake with fetch.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             de,
  input  logic             drw,
  input  logic [31:0]      daddr,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             int_req,
  input  logic             int_ack
);

  ic_state_e        state, state_d;
  logic             int_d;
  logic             ack_clr;
  logic             gie, gie_d;
  logic [N_IRQ-1:0] en;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic             is_mask, is_status;
  logic             wr_mask, wr_stat;
  logic             rd;
  logic             req;
  logic             unused;

  assign unused    = ^{daddr, din};
  assign is_mask   = daddr[SEL_BIT] == MASK_OFF[SEL_BIT];
  assign is_status = daddr[SEL_BIT] == STATUS_OFF[SEL_BIT];
  assign wr_mask   = de & drw & is_mask;
  assign wr_stat   = de & drw & is_status;
  assign rd        = de & ~drw;
  assign clr       = wr_stat ? din[N_IRQ:1] : '0;
  assign req       = gie & |(pending & en);

  int_pending #(.N_IRQ(N_IRQ)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .clr     (clr),
    .pending (pending)
  );

  always_comb begin
    state_d = state;
    int_d   = int_req;
    ack_clr = 1'b0;
    case (state)
      S_IC_IDLE: begin
        if (req) begin
          state_d = S_IC_REQ;
          int_d   = 1'b1;
        end
      end
      S_IC_REQ: begin
        if (int_ack) begin
          state_d = S_IC_SVC;
          int_d   = 1'b0;
          ack_clr = 1'b1;
        end
      end
      S_IC_SVC: begin
        if (!int_ack) state_d = S_IC_IDLE;
      end
      default: begin
        state_d = S_IC_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // Hardware GIE clear on acknowledge beats a software write.
  always_comb begin
    gie_d = gie;
    if (ack_clr)      gie_d = 1'b0;
    else if (wr_mask) gie_d = din[GIE_BIT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IC_IDLE;
      int_req <= 1'b0;
      gie     <= 1'b0;
      en      <= '0;
    end else begin
      state   <= state_d;
      int_req <= int_d;
      gie     <= gie_d;
      if (wr_mask) en <= din[N_IRQ:1];
    end
  end

  always_comb begin
    dout = '0;
    if (rd) begin
      if (is_status) dout = 32'({pending, 1'b0});
      else           dout = 32'({en, gie});
    end
  end

endmodule
